// File: rtl/cpu_ctrl_if.sv
// Control bundle between the phase sequencer and the 8-bit CPU datapath.
// The master side (control unit) drives every control input of the datapath
// and observes the instruction register and the ALU flags.
interface cpu_ctrl_if;
   // Datapath -> control
   logic [7:0] irvalue;   // [7:4]=opcode, [3:2]=rd, [1:0]=rs
   logic       zero;
   logic       negative;

   // Control -> datapath
   logic       irload;
   logic       imload;
   logic       pcsel;     // 0=PC+1, 1=imm
   logic       pcload;
   logic       readwrite; // 0=read, 1=write
   logic       dwrite;
   logic [1:0] dregsel;
   logic [1:0] sregsel;
   logic [1:0] aluop;
   logic [1:0] regsel;    // 00=aluout, 01=imm, 10=datain, 11=sbus
   logic [1:0] addrsel;   // 00=PC, 01=imm, 10=sbus, 11=dbus
   logic [2:0] phase;     // 000=FETCH 001=DECODE 010=IMM 011=EXEC 100=HALT

   modport master (
      input  irvalue, zero, negative,
      output irload, imload, pcsel, pcload, readwrite, dwrite,
             dregsel, sregsel, aluop, regsel, addrsel, phase
   );

   modport slave (
      output irvalue, zero, negative,
      input  irload, imload, pcsel, pcload, readwrite, dwrite,
             dregsel, sregsel, aluop, regsel, addrsel, phase
   );
endinterface

// File: rtl/cpu_control_unit.sv
// Phase-sequencing control FSM for the 8-bit Von Neumann CPU.
// FETCH -> DECODE -> [IMM] -> EXEC -> FETCH, or DECODE -> HALT for opcode 1111.
// Outputs are a Moore-style decode of the phase and the instruction register;
// the ALU flags are only consulted in EXEC for the conditional jumps.
module cpu_control_unit #(
   parameter bit ALLOW_HALT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   cpu_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      StFetch  = 3'b000,
      StDecode = 3'b001,
      StImm    = 3'b010,
      StExec   = 3'b011,
      StHalt   = 3'b100
   } phase_e;

   localparam logic [3:0] OpLi   = 4'b0100;
   localparam logic [3:0] OpLd   = 4'b0101;
   localparam logic [3:0] OpSt   = 4'b0110;
   localparam logic [3:0] OpLda  = 4'b0111;
   localparam logic [3:0] OpSta  = 4'b1000;
   localparam logic [3:0] OpJmp  = 4'b1001;
   localparam logic [3:0] OpJz   = 4'b1010;
   localparam logic [3:0] OpJn   = 4'b1011;
   localparam logic [3:0] OpHalt = 4'b1111;

   localparam logic [1:0] RegAlu    = 2'b00;
   localparam logic [1:0] RegImm    = 2'b01;
   localparam logic [1:0] RegDatain = 2'b10;

   localparam logic [1:0] AddrPc   = 2'b00;
   localparam logic [1:0] AddrImm  = 2'b01;
   localparam logic [1:0] AddrSbus = 2'b10;

   phase_e phase_q, phase_d;

   logic [3:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic       imm_form;
   logic       is_halt;

   // Raw decode, before the reset gate
   logic       irload_c;
   logic       imload_c;
   logic       pcsel_c;
   logic       pcload_c;
   logic       readwrite_c;
   logic       dwrite_c;
   logic [1:0] dregsel_c;
   logic [1:0] sregsel_c;
   logic [1:0] aluop_c;
   logic [1:0] regsel_c;
   logic [1:0] addrsel_c;

   assign opcode = bus.irvalue[7:4];
   assign rd     = bus.irvalue[3:2];
   assign rs     = bus.irvalue[1:0];

   // Instructions that carry a trailing immediate byte.
   always_comb begin
      imm_form = 1'b0;
      unique case (opcode)
         OpLi, OpLda, OpSta, OpJmp, OpJz, OpJn: imm_form = 1'b1;
         default:                               imm_form = 1'b0;
      endcase
   end

   assign is_halt = ALLOW_HALT && (opcode == OpHalt);

   // Phase register; reset abandons any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= StFetch;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Next-phase sequencing.
   always_comb begin
      phase_d = phase_q;
      unique case (phase_q)
         StFetch:  phase_d = StDecode;
         StDecode: begin
            if (is_halt) begin
               phase_d = StHalt;
            end else if (imm_form) begin
               phase_d = StImm;
            end else begin
               phase_d = StExec;
            end
         end
         StImm:    phase_d = StExec;
         StExec:   phase_d = StFetch;
         StHalt:   phase_d = StHalt;
         default:  phase_d = StFetch;
      endcase
   end

   // Control decode per phase and, in EXEC, per opcode.
   always_comb begin
      irload_c    = 1'b0;
      imload_c    = 1'b0;
      pcsel_c     = 1'b0;
      pcload_c    = 1'b0;
      readwrite_c = 1'b0;
      dwrite_c    = 1'b0;
      dregsel_c   = 2'b00;
      sregsel_c   = 2'b00;
      aluop_c     = 2'b00;
      regsel_c    = RegAlu;
      addrsel_c   = AddrPc;
      unique case (phase_q)
         StFetch: begin
            addrsel_c = AddrPc;
            irload_c  = 1'b1;
            pcload_c  = 1'b1;
         end
         StImm: begin
            // Immediate is always consumed, so PC advances even for untaken jumps.
            addrsel_c = AddrPc;
            imload_c  = 1'b1;
            pcload_c  = 1'b1;
         end
         StExec: begin
            dregsel_c = rd;
            sregsel_c = rs;
            case (opcode)
               4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                  aluop_c  = opcode[1:0];
                  regsel_c = RegAlu;
                  dwrite_c = 1'b1;
               end
               OpLi: begin
                  regsel_c = RegImm;
                  dwrite_c = 1'b1;
               end
               OpLd: begin
                  addrsel_c = AddrSbus;
                  regsel_c  = RegDatain;
                  dwrite_c  = 1'b1;
               end
               OpSt: begin
                  addrsel_c   = AddrSbus;
                  readwrite_c = 1'b1;
               end
               OpLda: begin
                  addrsel_c = AddrImm;
                  regsel_c  = RegDatain;
                  dwrite_c  = 1'b1;
               end
               OpSta: begin
                  addrsel_c   = AddrImm;
                  readwrite_c = 1'b1;
               end
               OpJmp: begin
                  pcsel_c  = 1'b1;
                  pcload_c = 1'b1;
               end
               OpJz: begin
                  pcsel_c  = 1'b1;
                  pcload_c = bus.zero;
               end
               OpJn: begin
                  pcsel_c  = 1'b1;
                  pcload_c = bus.negative;
               end
               default: begin
                  // 1100-1111 (1111 only reaches EXEC when HALT is disabled): NOP
               end
            endcase
         end
         StDecode, StHalt: begin
         end
         default: begin
         end
      endcase
   end

   // Reset holds every output low, even though phase already reads FETCH.
   always_comb begin
      bus.irload    = irload_c    & ~reset;
      bus.imload    = imload_c    & ~reset;
      bus.pcsel     = pcsel_c     & ~reset;
      bus.pcload    = pcload_c    & ~reset;
      bus.readwrite = readwrite_c & ~reset;
      bus.dwrite    = dwrite_c    & ~reset;
      bus.dregsel   = reset ? 2'b00 : dregsel_c;
      bus.sregsel   = reset ? 2'b00 : sregsel_c;
      bus.aluop     = reset ? 2'b00 : aluop_c;
      bus.regsel    = reset ? 2'b00 : regsel_c;
      bus.addrsel   = reset ? 2'b00 : addrsel_c;
      bus.phase     = phase_q;
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: two instances (HALT enabled and
// disabled) run the same instruction stream against a per-instruction model.
module tb_cpu_control_unit;

   typedef struct packed {
      logic       irload;
      logic       imload;
      logic       pcsel;
      logic       pcload;
      logic       readwrite;
      logic       dwrite;
      logic [1:0] dregsel;
      logic [1:0] sregsel;
      logic [1:0] aluop;
      logic [1:0] regsel;
      logic [1:0] addrsel;
      logic [2:0] phase;
   } ctl_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   cpu_ctrl_if bus_ha ();
   cpu_ctrl_if bus_nh ();

   cpu_control_unit #(.ALLOW_HALT(1'b1)) dut_ha (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_ha)
   );

   cpu_control_unit #(.ALLOW_HALT(1'b0)) dut_nh (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_nh)
   );

   ctl_t obs_ha, obs_nh;
   assign obs_ha = {bus_ha.irload, bus_ha.imload, bus_ha.pcsel, bus_ha.pcload,
                    bus_ha.readwrite, bus_ha.dwrite, bus_ha.dregsel, bus_ha.sregsel,
                    bus_ha.aluop, bus_ha.regsel, bus_ha.addrsel, bus_ha.phase};
   assign obs_nh = {bus_nh.irload, bus_nh.imload, bus_nh.pcsel, bus_nh.pcload,
                    bus_nh.readwrite, bus_nh.dwrite, bus_nh.dregsel, bus_nh.sregsel,
                    bus_nh.aluop, bus_nh.regsel, bus_nh.addrsel, bus_nh.phase};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction classes from the ISA table.
   function automatic bit has_imm(input logic [3:0] op);
      return (op == 4'd4) || (op == 4'd7) || (op == 4'd8) ||
             (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
   endfunction

   function automatic int instr_len(input logic [7:0] ir);
      return has_imm(ir[7:4]) ? 4 : 3;
   endfunction

   // Expected controls on cycle cyc of the instruction ir (cycle 0 = FETCH).
   function automatic ctl_t model(input int cyc, input logic [7:0] ir, input logic z,
                                  input logic n, input bit allow_halt);
      ctl_t e;
      int   op;
      e  = '0;
      op = int'(ir[7:4]);
      if (cyc == 0) begin
         e.phase = 3'd0; e.irload = 1'b1; e.pcload = 1'b1;
      end else if (cyc == 1) begin
         e.phase = 3'd1;
      end else if (allow_halt && op == 15) begin
         e.phase = 3'd4;
      end else if (has_imm(ir[7:4]) && cyc == 2) begin
         e.phase = 3'd2; e.imload = 1'b1; e.pcload = 1'b1;
      end else begin
         e.phase   = 3'd3;
         e.dregsel = ir[3:2];
         e.sregsel = ir[1:0];
         if (op < 4) begin
            e.aluop = ir[5:4]; e.dwrite = 1'b1;
         end else if (op == 4) begin
            e.regsel = 2'd1; e.dwrite = 1'b1;
         end else if (op == 5) begin
            e.addrsel = 2'd2; e.regsel = 2'd2; e.dwrite = 1'b1;
         end else if (op == 6) begin
            e.addrsel = 2'd2; e.readwrite = 1'b1;
         end else if (op == 7) begin
            e.addrsel = 2'd1; e.regsel = 2'd2; e.dwrite = 1'b1;
         end else if (op == 8) begin
            e.addrsel = 2'd1; e.readwrite = 1'b1;
         end else if (op == 9) begin
            e.pcsel = 1'b1; e.pcload = 1'b1;
         end else if (op == 10) begin
            e.pcsel = 1'b1; e.pcload = z;
         end else if (op == 11) begin
            e.pcsel = 1'b1; e.pcload = n;
         end
      end
      return e;
   endfunction

   task automatic drive(input logic [7:0] ir, input logic z, input logic n);
      bus_ha.irvalue = ir; bus_ha.zero = z; bus_ha.negative = n;
      bus_nh.irvalue = ir; bus_nh.zero = z; bus_nh.negative = n;
   endtask

   task automatic check_idle(input string name);
      total++;
      if (obs_ha !== '0 || obs_nh !== '0) begin
         bad++;
         $display("FAIL %s: got ha=%h nh=%h, want all zero", name, obs_ha, obs_nh);
      end
   endtask

   // Entered just after an edge; leaves just after an edge with reset released.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_idle("reset_async");
      @(posedge clk); #1;
      check_idle("reset_held");
      reset = 1'b0;
   endtask

   // Runs one instruction from FETCH on both instances; flags are random
   // except in EXEC, where they take z/n.
   task automatic run_instr(input string name, input logic [7:0] ir,
                            input logic z, input logic n);
      int   len;
      int   seq_inc;
      ctl_t e_ha, e_nh;
      logic fz, fn;
      len     = instr_len(ir);
      seq_inc = 0;
      for (int c = 0; c < len; c++) begin
         if (c == len - 1) begin
            fz = z; fn = n;
         end else begin
            fz = 1'($urandom); fn = 1'($urandom);
         end
         drive(ir, fz, fn);
         #1;
         e_ha = model(c, ir, fz, fn, 1'b1);
         e_nh = model(c, ir, fz, fn, 1'b0);
         total++;
         if (obs_ha !== e_ha) begin
            bad++;
            $display("FAIL %s ha cyc=%0d ir=%h: got %h want %h", name, c, ir, obs_ha, e_ha);
         end
         total++;
         if (obs_nh !== e_nh) begin
            bad++;
            $display("FAIL %s nh cyc=%0d ir=%h: got %h want %h", name, c, ir, obs_nh, e_nh);
         end
         total++;
         if ((obs_ha.readwrite && obs_ha.dwrite) || (obs_ha.irload && obs_ha.imload)) begin
            bad++;
            $display("FAIL %s exclusion cyc=%0d: got %h want disjoint enables", name, c, obs_ha);
         end
         if (obs_ha.pcload && !obs_ha.pcsel) seq_inc++;
         @(posedge clk); #1;
      end
      total++;
      if (seq_inc != (has_imm(ir[7:4]) ? 2 : 1)) begin
         bad++;
         $display("FAIL %s pc_advance ir=%h: got %0d want %0d", name, ir, seq_inc,
                  has_imm(ir[7:4]) ? 2 : 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      do_reset();
      run_instr("reset_alu", 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_li();
      run_instr("li_r3", 8'h4D, 1'b0, 1'b0);
   endtask

   task automatic test_st();
      run_instr("st", 8'h69, 1'b1, 1'b1);
   endtask

   task automatic test_jz();
      run_instr("jz_not_taken", 8'hA0, 1'b0, 1'b1);
      run_instr("jz_taken", 8'hA0, 1'b1, 1'b0);
      run_instr("jn_taken", 8'hB5, 1'b0, 1'b1);
   endtask

   task automatic test_halt();
      ctl_t e_ha, e_nh;
      logic fz, fn;
      for (int c = 0; c < 12; c++) begin
         fz = 1'($urandom); fn = 1'($urandom);
         drive(8'hF0, fz, fn);
         #1;
         e_ha = model(c, 8'hF0, fz, fn, 1'b1);
         e_nh = model(c % 3, 8'hF0, fz, fn, 1'b0);
         total++;
         if (obs_ha !== e_ha) begin
            bad++;
            $display("FAIL halt ha cyc=%0d: got %h want %h", c, obs_ha, e_ha);
         end
         total++;
         if (obs_nh !== e_nh) begin
            bad++;
            $display("FAIL halt_nop nh cyc=%0d: got %h want %h", c, obs_nh, e_nh);
         end
         @(posedge clk); #1;
      end
      do_reset();
      run_instr("after_halt", 8'h1E, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      ctl_t e;
      for (int c = 0; c < 3; c++) begin
         drive(8'h7B, 1'b0, 1'b0);
         #1;
         e = model(c, 8'h7B, 1'b0, 1'b0, 1'b1);
         total++;
         if (obs_ha !== e) begin
            bad++;
            $display("FAIL lda_pre cyc=%0d: got %h want %h", c, obs_ha, e);
         end
         if (c < 2) begin
            @(posedge clk); #1;
         end
      end
      // Now mid-IMM: reset must kill imload immediately.
      do_reset();
      run_instr("post_reset_lda", 8'h7B, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] ir;
      for (int i = 0; i < 60; i++) begin
         ir = 8'($urandom);
         if (ir[7:4] == 4'hF) ir[7:4] = 4'($urandom_range(0, 14));
         run_instr("random", ir, 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_sta", 8'h8C, 1'b0, 1'b0);
      run_instr("b2b_ld", 8'h57, 1'b0, 1'b0);
      run_instr("b2b_jmp", 8'h90, 1'b0, 1'b0);
      run_instr("b2b_nop", 8'hC3, 1'b1, 1'b1);
      run_instr("b2b_sub", 8'h2B, 1'b0, 1'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(8'h00, 1'b0, 1'b0);
      test_reset();
      test_li();
      test_st();
      test_jz();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Phase-sequencing control FSM for the 8-bit Von Neumann CPU; drives every control input of the `cpu` datapath, previously driven only by the testbench.
- Consumes `irvalue` and ALU flags `zero`/`negative` from the datapath.
- Produces `irload`, `imload`, `pcsel`, `pcload`, `readwrite`, `dwrite`, `dregsel`, `sregsel`, `aluop`, `regsel` and `addrsel`.
- Sits between the instruction register and the datapath, replacing testbench stimulus.

Parameters:
ALLOW_HALT, 1, 1: opcode 1111 enters HALT; 0: opcode 1111 executes as NOP.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
irvalue  input  8  current IR contents; [7:4]=opcode, [3:2]=rd, [1:0]=rs
zero  input  1  ALU zero flag, sampled in EXEC
negative  input  1  ALU negative flag, sampled in EXEC
irload  output  1  load IR from datain
imload  output  1  load immediate register from datain
pcsel  output  1  PC source select: 0=PC+1, 1=imm
pcload  output  1  PC write enable
readwrite  output  1  memory access: 0=read, 1=write (data from dbus)
dwrite  output  1  register file write enable (writes register dregsel)
dregsel  output  2  destination/dbus register select
sregsel  output  2  source/sbus register select
aluop  output  2  ALU operation
regsel  output  2  register write data source: 00=aluout, 01=imm, 10=datain, 11=sbus
addrsel  output  2  memory address source: 00=PC, 01=imm, 10=sbus, 11=dbus
phase  output  3  current phase: 000=FETCH, 001=DECODE, 010=IMM, 011=EXEC, 100=HALT

Behaviour:
- Reset (asynchronous): phase <= FETCH. While reset is high, all enables (`irload`, `imload`, `pcload`, `dwrite`, `readwrite`) are forced to 0; all select outputs read 0.
- Outputs: combinational decode of phase and irvalue, Moore-style. `irvalue` is stable from DECODE onward; the IR is not reloaded until the next FETCH.
- Defaults: every output not listed for a phase is 0.
- FETCH:
  - Outputs: addrsel=00, irload=1, pcload=1, pcsel=0.
  - Next: DECODE.
- DECODE:
  - Outputs: none.
  - Next: IMM for opcodes LI, LDA, STA, JMP, JZ, JN; HALT for 1111 when ALLOW_HALT=1; otherwise EXEC.
- IMM:
  - Outputs: addrsel=00, imload=1, pcload=1, pcsel=0.
  - Next: EXEC.
- EXEC: outputs per opcode, listed below. Next: FETCH.
- HALT:
  - Outputs: none.
  - Remains in HALT until reset.
- Opcode actions in EXEC (dregsel=rd and sregsel=rs throughout):
  - 00xx, ALU: aluop=opcode[1:0], regsel=00, dwrite=1.
  - 0100, LI: regsel=01, dwrite=1.
  - 0101, LD: addrsel=10, regsel=10, dwrite=1.
  - 0110, ST: addrsel=10, readwrite=1.
  - 0111, LDA: addrsel=01, regsel=10, dwrite=1.
  - 1000, STA: addrsel=01, readwrite=1.
  - 1001, JMP: pcsel=1, pcload=1.
  - 1010, JZ: pcsel=1, pcload=zero.
  - 1011, JN: pcsel=1, pcload=negative.
  - 1100-1110: NOP, no enables asserted.
  - 1111 with ALLOW_HALT=0: NOP.
- Latency:
  - 3 cycles: register/ALU, LD, ST, NOP.
  - 4 cycles: immediate-form instructions. The immediate byte is always consumed, so PC advances by 2, even for a not-taken branch.
- Flags are sampled combinationally in EXEC only. Flag changes in other phases have no effect.
- Mutual exclusion: `readwrite` and `dwrite` are never both 1. `irload` and `imload` are never both 1.
- Reset asserted mid-instruction: the instruction is abandoned and no further enables are asserted. After release, the FSM starts at FETCH on the next rising edge.

Test Plan:
- Reset then release, irvalue=8'h00 -> FETCH cycle shows irload=1, pcload=1, addrsel=00; phase sequence is 000,001,011,000; EXEC shows dwrite=1, regsel=00, aluop=00, dregsel=00, sregsel=00.
- irvalue=8'h4D (LI r3) -> phase sequence is 000,001,010,011; IMM shows imload=1, pcload=1; EXEC shows regsel=01, dwrite=1, dregsel=11.
- irvalue=8'h69 (ST rd=2, rs=1) -> EXEC shows addrsel=10, readwrite=1, dwrite=0, dregsel=10, sregsel=01.
- irvalue=8'hA0 (JZ) with zero=0, then repeated with zero=1 -> EXEC shows pcload=0 then pcload=1, pcsel=1 both times; IMM pcload=1 in both cases.
- irvalue=8'hF0 with ALLOW_HALT=1 -> phase enters 100 after DECODE and stays there for 10 cycles with all enables 0; asserting reset returns phase to 000.
- Reset asserted during IMM of an LDA -> imload drops to 0 within the same cycle, no EXEC occurs, and after release the FSM starts at FETCH.
